// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the race game drawing path: screen geometry, the
// coordinate and colour widths of the 160x120 VGA adapter, the colour
// constants, and the state encoding of the box plotter FSM.
// No ports (package).
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] RED   = 3'b100;
    localparam logic [COLOUR_W-1:0] BLUE  = 3'b001;
    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } plot_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. The grant is combinational from the request
// lines; the fairness history (last_grant) only advances when the consumer
// actually takes the grant, so a grant offered while the consumer is busy
// does not disturb the rotation.
//
// Ports:
//   clk     in   system clock
//   resetn  in   synchronous active-low reset (last_grant -> 1)
//   req     in   [1:0] request lines, bit i = player i
//   accept  in   consumer takes the current grant this cycle
//   grant   out  [1:0] one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // Index of the player granted most recently. Resetting to 1 means
    // player 0 wins the very first tie.
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            // Tie: hand the grant to whoever did not get it last time.
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/box_plotter.sv
// -----------------------------------------------------------------------------
// box_plotter
// Drawing stage between the two per-player race FSMs and the 160x120 VGA
// adapter. Takes box requests from two players, picks one round-robin, and
// rasterises a BOX_W x BOX_H box at one pixel per cycle. Only one box is on
// the pixel port at a time. Pixels falling off the right or bottom edge of
// the screen are suppressed but still take their cycle.
//
// Build option: BOX_PLOTTER_OUTLINE_EN
//   defined   -> only the border pixels of the box are plotted
//   undefined -> solid fill
//
// Parameters:
//   BOX_W  box width  in pixels (1..16)
//   BOX_H  box height in pixels (1..16)
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   p0_req/x/y/colour, p0_ack   player 0 request channel
//   p1_req/x/y/colour, p1_ack   player 1 request channel
//   vga_x, vga_y, vga_colour    pixel to the adapter
//   vga_plot                    adapter write enable
//   busy                        high in any state other than IDLE
//   done                        one-cycle pulse when a box finishes
//   dbg_state                   current FSM state (plot_state_t encoding)
//
// Request handshake: pN_req is a level that the player holds, together with
// stable x/y/colour, until it sees pN_ack. pN_ack is a one-cycle pulse on the
// cycle after the request was captured; the captured coordinates are private
// to this block from then on, so the player may change them or drop req.
// A req still high after its ack counts as a new request.
//
// All outputs are registered: the output process computes the value each
// output will carry after the coming clock edge.
// -----------------------------------------------------------------------------
module box_plotter
    import game_pkg::*;
#(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                p0_req,
    input  logic [X_W-1:0]      p0_x,
    input  logic [Y_W-1:0]      p0_y,
    input  logic [COLOUR_W-1:0] p0_colour,
    output logic                p0_ack,
    input  logic                p1_req,
    input  logic [X_W-1:0]      p1_x,
    input  logic [Y_W-1:0]      p1_y,
    input  logic [COLOUR_W-1:0] p1_colour,
    output logic                p1_ack,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);

    // Offsets are always 4 bits wide so BOX_W/BOX_H = 1 still elaborate.
    localparam logic [3:0] DX_LAST = 4'(BOX_W - 1);
    localparam logic [3:0] DY_LAST = 4'(BOX_H - 1);

    localparam logic [X_W:0] X_MAX = (X_W + 1)'(SCREEN_W - 1);
    localparam logic [Y_W:0] Y_MAX = (Y_W + 1)'(SCREEN_H - 1);

    plot_state_t state, state_next;

    logic [X_W-1:0]      bx;
    logic [Y_W-1:0]      by;
    logic [COLOUR_W-1:0] bc;
    logic [3:0]          dx;
    logic [3:0]          dy;

    logic [1:0] grant;
    logic       accept;
    logic       last_px;

    // One bit wider than the coordinate so the off-screen test sees the carry.
    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;
    logic         in_screen;
    logic         on_border;

    // Next-cycle output values.
    logic                p0_ack_n, p1_ack_n;
    logic [X_W-1:0]      vga_x_n;
    logic [Y_W-1:0]      vga_y_n;
    logic [COLOUR_W-1:0] vga_colour_n;
    logic                vga_plot_n, busy_n, done_n;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    rr_arbiter2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    ({p1_req, p0_req}),
        .accept (accept),
        .grant  (grant)
    );

    assign accept = (state == IDLE) && (grant != 2'b00);

    // -------------------------------------------------------------------------
    // Raster position and clipping
    // -------------------------------------------------------------------------
    assign last_px   = (dx == DX_LAST) && (dy == DY_LAST);
    assign sum_x     = {1'b0, bx} + {{(X_W - 3){1'b0}}, dx};
    assign sum_y     = {1'b0, by} + {{(Y_W - 3){1'b0}}, dy};
    assign in_screen = (sum_x <= X_MAX) && (sum_y <= Y_MAX);

`ifdef BOX_PLOTTER_OUTLINE_EN
    assign on_border = (dx == 4'd0) || (dx == DX_LAST) ||
                       (dy == 4'd0) || (dy == DY_LAST);
`else
    assign on_border = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)  state_next = DRAW;
            DRAW:    if (last_px) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (values presented after the coming edge)
    // -------------------------------------------------------------------------
    always_comb begin
        p0_ack_n     = 1'b0;
        p1_ack_n     = 1'b0;
        vga_x_n      = '0;
        vga_y_n      = '0;
        vga_colour_n = '0;
        vga_plot_n   = 1'b0;
        busy_n       = 1'b0;
        done_n       = 1'b0;
        case (state)
            IDLE: begin
                p0_ack_n = accept && grant[0];
                p1_ack_n = accept && grant[1];
                busy_n   = accept;
            end
            DRAW: begin
                vga_x_n      = sum_x[X_W-1:0];
                vga_y_n      = sum_y[Y_W-1:0];
                vga_colour_n = bc;
                vga_plot_n   = in_screen && on_border;
                busy_n       = 1'b1;
            end
            DONE: begin
                // busy stays high through the done cycle; it drops one edge
                // later, on the first IDLE edge.
                done_n = 1'b1;
                busy_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            p0_ack     <= p0_ack_n;
            p1_ack     <= p1_ack_n;
            vga_x      <= vga_x_n;
            vga_y      <= vga_y_n;
            vga_colour <= vga_colour_n;
            vga_plot   <= vga_plot_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // Box registers and raster counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bx <= '0;
            by <= '0;
            bc <= '0;
            dx <= '0;
            dy <= '0;
        end else if (accept) begin
            bx <= grant[1] ? p1_x      : p0_x;
            by <= grant[1] ? p1_y      : p0_y;
            bc <= grant[1] ? p1_colour : p0_colour;
            dx <= '0;
            dy <= '0;
        end else if (state == DRAW) begin
            if (dx == DX_LAST) begin
                dx <= '0;
                dy <= dy + 4'd1;
            end else begin
                dx <= dx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_box_plotter.sv
// -----------------------------------------------------------------------------
// tb_box_plotter
// Directed bench for box_plotter with a 4x4 box. Inputs change 2 time units
// after a rising edge; outputs are read at the same point, so every read
// shows the registered value produced by the preceding edge. A background
// monitor logs plotted pixels, ack pulses and done pulses 1 time unit after
// each rising edge; the scenario tasks compare those logs against an
// expected pixel list built from a small reference model of the raster.
// Build option BOX_PLOTTER_OUTLINE_EN switches the model to outline mode.
// -----------------------------------------------------------------------------
module tb_box_plotter;
    import game_pkg::*;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                p0_req = 1'b0, p1_req = 1'b0;
    logic [X_W-1:0]      p0_x = '0, p1_x = '0;
    logic [Y_W-1:0]      p0_y = '0, p1_y = '0;
    logic [COLOUR_W-1:0] p0_colour = '0, p1_colour = '0;
    logic                p0_ack, p1_ack;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot, busy, done;
    logic [1:0]          dbg_state;

    always #5 clk = ~clk;

    box_plotter #(.BOX_W(4), .BOX_H(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .p0_req     (p0_req),
        .p0_x       (p0_x),
        .p0_y       (p0_y),
        .p0_colour  (p0_colour),
        .p0_ack     (p0_ack),
        .p1_req     (p1_req),
        .p1_x       (p1_x),
        .p1_y       (p1_y),
        .p1_colour  (p1_colour),
        .p1_ack     (p1_ack),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // -------------------------------------------------------------------------
    // Monitor logs and expected queue
    // -------------------------------------------------------------------------
    int          cyc = 0;
    logic [17:0] plot_q[$];   // {x, y, colour} of every plotted pixel
    logic [17:0] exp_q[$];
    int          ack_p[$];    // which player was acked
    int          ack_c[$];    // cycle number of that ack
    int          done_cnt = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (vga_plot) plot_q.push_back({vga_x, vga_y, vga_colour});
        if (p0_ack) begin ack_p.push_back(0); ack_c.push_back(cyc); end
        if (p1_ack) begin ack_p.push_back(1); ack_c.push_back(cyc); end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs;
        plot_q.delete();
        exp_q.delete();
        ack_p.delete();
        ack_c.delete();
        done_cnt = 0;
    endtask

    // Reference raster for a 4x4 box at (x, y): raster order, off-screen
    // pixels dropped, interior dropped in outline mode.
    task automatic build_exp(input int x, input int y, input logic [2:0] c);
        bit keep;
        for (int ddy = 0; ddy < 4; ddy++) begin
            for (int ddx = 0; ddx < 4; ddx++) begin
                keep = (x + ddx <= 159) && (y + ddy <= 119);
`ifdef BOX_PLOTTER_OUTLINE_EN
                keep = keep && (ddx == 0 || ddx == 3 || ddy == 0 || ddy == 3);
`endif
                if (keep) exp_q.push_back({8'(x + ddx), 7'(y + ddy), c});
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset;
        resetn = 1'b0;
        tick;
        tick;
        n_checks++; if (vga_plot !== 1'b0) begin n_errors++; $display("FAIL reset_plot got %0b exp 0", vga_plot); end
        n_checks++; if ({vga_x, vga_y, vga_colour} !== 18'd0) begin n_errors++; $display("FAIL reset_pixel got %0h exp 0", {vga_x, vga_y, vga_colour}); end
        n_checks++; if ({busy, done, p0_ack, p1_ack} !== 4'b0000) begin n_errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, p0_ack, p1_ack}); end
        n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        resetn = 1'b1;
        tick;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle_busy got %0b exp 0", busy); end
    endtask

    task automatic test_single;
        clear_logs();
        build_exp(38, 100, RED);
        p0_x = 8'd38; p0_y = 7'd100; p0_colour = RED; p0_req = 1'b1;
        tick; // E0
        n_checks++; if ({p0_ack, p1_ack, busy, vga_plot} !== 4'b1010) begin n_errors++; $display("FAIL single_e0 ack0/ack1/busy/plot got %b exp 1010", {p0_ack, p1_ack, busy, vga_plot}); end
        p0_req = 1'b0;
        tick; // E1
        n_checks++; if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd38, 7'd100, RED}) begin n_errors++; $display("FAIL single_first_px got %0h exp %0h", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, 8'd38, 7'd100, RED}); end
        n_checks++; if (p0_ack !== 1'b0) begin n_errors++; $display("FAIL single_ack_width got %0b exp 0", p0_ack); end
        repeat (15) tick; // E16
        n_checks++; if ({vga_x, vga_y} !== {8'd41, 7'd103}) begin n_errors++; $display("FAIL single_last_px got %0d,%0d exp 41,103", vga_x, vga_y); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL single_done_early got %0b exp 0", done); end
        tick; // E17
        n_checks++; if ({done, busy, vga_plot} !== 3'b110) begin n_errors++; $display("FAIL single_e17 done/busy/plot got %b exp 110", {done, busy, vga_plot}); end
        tick; // E18
        n_checks++; if ({done, busy} !== 2'b00) begin n_errors++; $display("FAIL single_e18 done/busy got %b exp 00", {done, busy}); end
        n_checks++; if (plot_q.size() !== exp_q.size()) begin n_errors++; $display("FAIL single_count got %0d exp %0d", plot_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < plot_q.size(); i++) begin
            n_checks++; if (plot_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL single_px[%0d] got %0h exp %0h", i, plot_q[i], exp_q[i]); end
        end
        n_checks++; if (ack_p.size() !== 1 || done_cnt !== 1) begin n_errors++; $display("FAIL single_pulses acks %0d dones %0d exp 1 1", ack_p.size(), done_cnt); end
    endtask

    task automatic test_simultaneous;
        resetn = 1'b0;
        p0_x = 8'd38;  p0_y = 7'd100; p0_colour = RED;  p0_req = 1'b1;
        p1_x = 8'd118; p1_y = 7'd100; p1_colour = BLUE; p1_req = 1'b1;
        tick;
        clear_logs();
        build_exp(38, 100, RED);
        build_exp(118, 100, BLUE);
        resetn = 1'b1;
        tick; // E0
        n_checks++; if ({p0_ack, p1_ack} !== 2'b10) begin n_errors++; $display("FAIL simul_first_grant ack0/ack1 got %b exp 10", {p0_ack, p1_ack}); end
        p0_req = 1'b0;
        repeat (17) tick; // E17
        n_checks++; if ({done, p1_ack} !== 2'b10) begin n_errors++; $display("FAIL simul_e17 done/ack1 got %b exp 10", {done, p1_ack}); end
        tick; // E18: first IDLE edge grants p1
        n_checks++; if ({p0_ack, p1_ack, busy} !== 3'b011) begin n_errors++; $display("FAIL simul_second_grant ack0/ack1/busy got %b exp 011", {p0_ack, p1_ack, busy}); end
        p1_req = 1'b0;
        repeat (17) tick; // E35
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL simul_done2 got %0b exp 1", done); end
        tick; // E36
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL simul_idle got %0b exp 0", busy); end
        n_checks++; if (plot_q.size() !== exp_q.size()) begin n_errors++; $display("FAIL simul_count got %0d exp %0d", plot_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < plot_q.size(); i++) begin
            n_checks++; if (plot_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL simul_px[%0d] got %0h exp %0h", i, plot_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_round_robin;
        resetn = 1'b0;
        p0_x = 8'd10; p0_y = 7'd10; p0_colour = RED;  p0_req = 1'b1;
        p1_x = 8'd60; p1_y = 7'd40; p1_colour = BLUE; p1_req = 1'b1;
        tick;
        clear_logs();
        build_exp(10, 10, RED);
        build_exp(60, 40, BLUE);
        build_exp(10, 10, RED);
        build_exp(60, 40, BLUE);
        resetn = 1'b1;
        repeat (72) tick; // E0..E71: grants at E0, E18, E36, E54
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (20) tick;
        n_checks++; if (ack_p.size() !== 4) begin n_errors++; $display("FAIL rr_ack_count got %0d exp 4", ack_p.size()); end
        for (int i = 0; i < 4 && i < ack_p.size(); i++) begin
            n_checks++; if (ack_p[i] !== (i % 2)) begin n_errors++; $display("FAIL rr_order[%0d] got p%0d exp p%0d", i, ack_p[i], i % 2); end
            n_checks++; if (ack_c[i] - ack_c[0] !== 18 * i) begin n_errors++; $display("FAIL rr_spacing[%0d] got %0d exp %0d", i, ack_c[i] - ack_c[0], 18 * i); end
        end
        n_checks++; if (done_cnt !== 4 || busy !== 1'b0) begin n_errors++; $display("FAIL rr_end dones %0d busy %0b exp 4 0", done_cnt, busy); end
        n_checks++; if (plot_q.size() !== exp_q.size()) begin n_errors++; $display("FAIL rr_count got %0d exp %0d", plot_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < plot_q.size(); i++) begin
            n_checks++; if (plot_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rr_px[%0d] got %0h exp %0h", i, plot_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_clip;
        clear_logs();
        build_exp(158, 118, BLUE);
        p1_x = 8'd158; p1_y = 7'd118; p1_colour = BLUE; p1_req = 1'b1;
        tick; // E0
        n_checks++; if ({p0_ack, p1_ack} !== 2'b01) begin n_errors++; $display("FAIL clip_grant ack0/ack1 got %b exp 01", {p0_ack, p1_ack}); end
        p1_req = 1'b0;
        tick; // E1
        n_checks++; if ({vga_plot, vga_x, vga_y} !== {1'b1, 8'd158, 7'd118}) begin n_errors++; $display("FAIL clip_first_px got %0h exp %0h", {vga_plot, vga_x, vga_y}, {1'b1, 8'd158, 7'd118}); end
        tick; tick; // E3: dx=2 -> x 160 is off-screen
        n_checks++; if (vga_plot !== 1'b0) begin n_errors++; $display("FAIL clip_offscreen got %0b exp 0", vga_plot); end
        repeat (13) tick; // E16
        n_checks++; if ({busy, done} !== 2'b10) begin n_errors++; $display("FAIL clip_e16 busy/done got %b exp 10", {busy, done}); end
        tick; // E17
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL clip_done got %0b exp 1", done); end
        tick; // E18
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL clip_idle got %0b exp 0", busy); end
        n_checks++; if (plot_q.size() !== exp_q.size()) begin n_errors++; $display("FAIL clip_count got %0d exp %0d", plot_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < plot_q.size(); i++) begin
            n_checks++; if (plot_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL clip_px[%0d] got %0h exp %0h", i, plot_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_draw;
        clear_logs();
        build_exp(10, 20, RED);
        p0_x = 8'd10; p0_y = 7'd20; p0_colour = RED; p0_req = 1'b1;
        tick; // E0
        n_checks++; if (p0_ack !== 1'b1) begin n_errors++; $display("FAIL rst_mid_grant got %0b exp 1", p0_ack); end
        repeat (5) tick; // E5: fifth pixel on the port
        resetn = 1'b0;
        tick;
        n_checks++; if ({vga_plot, busy, done, p0_ack, p1_ack} !== 5'b00000) begin n_errors++; $display("FAIL rst_mid_flags got %b exp 00000", {vga_plot, busy, done, p0_ack, p1_ack}); end
        n_checks++; if ({vga_x, vga_y, vga_colour} !== 18'd0 || dbg_state !== 2'd0) begin n_errors++; $display("FAIL rst_mid_pixel got %0h state %0d exp 0 0", {vga_x, vga_y, vga_colour}, dbg_state); end
        tick;
        resetn = 1'b1;
        tick; // fresh grant, request still held
        n_checks++; if (p0_ack !== 1'b1) begin n_errors++; $display("FAIL rst_mid_regrant got %0b exp 1", p0_ack); end
        p0_req = 1'b0;
        tick;
        n_checks++; if ({vga_x, vga_y} !== {8'd10, 7'd20}) begin n_errors++; $display("FAIL rst_mid_restart got %0d,%0d exp 10,20", vga_x, vga_y); end
        repeat (16) tick; // done of the redraw
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rst_mid_done got %0b exp 1", done); end
        tick;
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL rst_mid_done_count got %0d exp 1", done_cnt); end
        n_checks++; if (plot_q.size() !== 5 + exp_q.size()) begin n_errors++; $display("FAIL rst_mid_count got %0d exp %0d", plot_q.size(), 5 + exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i + 5 < plot_q.size(); i++) begin
            n_checks++; if (plot_q[i + 5] !== exp_q[i]) begin n_errors++; $display("FAIL rst_mid_px[%0d] got %0h exp %0h", i, plot_q[i + 5], exp_q[i]); end
        end
    endtask

    task automatic test_outline;
        int  exp_n;
        bit  seen_interior;
        clear_logs();
        build_exp(43, 88, RED);
`ifdef BOX_PLOTTER_OUTLINE_EN
        exp_n = 12;
`else
        exp_n = 16;
`endif
        p0_x = 8'd43; p0_y = 7'd88; p0_colour = RED; p0_req = 1'b1;
        tick; // E0
        p0_req = 1'b0;
        repeat (17) tick; // E17
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL outline_done got %0b exp 1", done); end
        tick;
        n_checks++; if (plot_q.size() !== exp_n) begin n_errors++; $display("FAIL outline_count got %0d exp %0d", plot_q.size(), exp_n); end
        seen_interior = 1'b0;
        foreach (plot_q[i]) if (plot_q[i][17:3] == {8'd44, 7'd89}) seen_interior = 1'b1;
        n_checks++; if (seen_interior !== (exp_n == 16)) begin n_errors++; $display("FAIL outline_interior got %0b exp %0b", seen_interior, exp_n == 16); end
        for (int i = 0; i < exp_q.size() && i < plot_q.size(); i++) begin
            n_checks++; if (plot_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL outline_px[%0d] got %0h exp %0h", i, plot_q[i], exp_q[i]); end
        end
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_clip();
        test_reset_mid_draw();
        test_outline();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/box_plotter.md
# box_plotter

Downstream drawing stage between the two per-player race FSMs and the 160x120 VGA adapter. Accepts box-draw requests (top-left x, y, colour) from player 0 and player 1, arbitrates round-robin, and rasterises each BOX_W x BOX_H box into one-pixel-per-cycle plot writes. Guarantees that no two boxes interleave on the adapter's single pixel port.

## Interface
- BOX_W, 4: box width in pixels (1..16)
- BOX_H, 4: box height in pixels (1..16)
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- p0_req  in  1  player 0 request; level, held until p0_ack
- p0_x  in  8  player 0 box top-left x
- p0_y  in  7  player 0 box top-left y
- p0_colour  in  3  player 0 box colour
- p0_ack  out  1  one-cycle pulse: p0 request captured
- p1_req, p1_x, p1_y, p1_colour, p1_ack: same as p0, for player 1
- vga_x  out  8  pixel x to adapter
- vga_y  out  7  pixel y to adapter
- vga_colour  out  3  pixel colour to adapter
- vga_plot  out  1  write enable to adapter
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a box finishes

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: if any req is high, grant one, latch its x/y/colour into bx/by/bc, pulse that ack, clear dx/dy, go to DRAW.
- Arbitration: round-robin. A last_grant register resets to 1, so p0 wins the first tie. On a tie, grant the player not in last_grant. A single requester always wins.
- DRAW: each cycle drive vga_x = bx+dx, vga_y = by+dy, vga_colour = bc, vga_plot = 1.
  - dx counts 0..BOX_W-1; on wrap, dx -> 0 and dy++.
  - After pixel (BOX_W-1, BOX_H-1), go to DONE.
- DONE: done = 1 and vga_plot = 0 for one cycle, then go to IDLE.
- Clipping: compute sums 1 bit wider than the coordinate. Suppress vga_plot on any pixel with bx+dx > 159 or by+dy > 119. Cycle count is unchanged by clipping.
- Requests arriving while busy wait; req must stay high until ack. The block never drops a held request.
- Reset values: all outputs 0, state IDLE, dx = dy = 0, bx/by/bc = 0, last_grant = 1.
- Reset mid-DRAW: abort immediately, with no done pulse. Pending reqs are re-arbitrated from IDLE after reset releases.

## Timing
- All outputs are registered.
- Req sampled high in IDLE at edge E0: ack = 1 and busy = 1 after E0.
- First pixel is valid after E1. The last pixel is valid after E(BOX_W*BOX_H).
- done is high after E(BOX_W*BOX_H+1), with busy still 1. After the next edge busy = 0.
- The earliest next grant is at that same edge (the first IDLE edge).
- Throughput: BOX_W*BOX_H+2 cycles per box. Default = 18.
- ack is exactly one cycle and goes only to the granted player.

## Configuration
- BOX_PLOTTER_OUTLINE_EN defined: vga_plot is asserted only on border pixels (dx == 0, dx == BOX_W-1, dy == 0 or dy == BOX_H-1), combined with clipping. The raster and cycle count are identical to solid fill.
- Undefined: solid fill; every in-screen pixel is plotted.

## Structure
- Shared package game_pkg holds:
  - SCREEN_W = 160, SCREEN_H = 120
  - X_W = 8, Y_W = 7, COLOUR_W = 3
  - colour constants RED = 3'b100, BLUE = 3'b001, BLACK = 3'b000
  - plotter state enum {IDLE, DRAW, DONE}
- One sub-module: rr_arbiter2. It is a 2-way round-robin grant with a last_grant register, updated only when the FSM accepts a grant.
- The raster counters and clipping logic live in box_plotter.

## Test plan
- Single request: p0_req with x=38, y=100, colour=100. Expect p0_ack after E0, and 16 plots covering x 38..41, y 100..103 in raster order. done after E17, busy low after E18.
- Simultaneous: p0_req and p1_req both high from reset (p1 x=118, y=100, colour=001). Expect p0 granted first and p1 acked at its first IDLE edge. Expect 32 plots total, with no interleaving.
- Round-robin fairness: both reqs held high continuously for 4 boxes. Expect grant order p0, p1, p0, p1, each ack exactly one cycle.
- Clipping: p1 x=158, y=118. Expect 4 plotted pixels ((158,118), (159,118), (158,119), (159,119)) and 16 DRAW cycles. done still at E17.
- Reset mid-draw: resetn low after pixel 5 of a box. Expect all outputs 0 the next cycle and no done. With the req held, a fresh grant follows reset release, redrawing from (0,0) offset.
- With BOX_PLOTTER_OUTLINE_EN: x=43, y=88. Expect 12 plots; interior pixels (44,89), (45,89), (44,90), (45,90) not plotted.
